// File: rtl/uart_fifo_tx.sv
// uart_fifo_tx: drains bytes from a normal-mode FIFO and sends them as 8N1 UART frames, LSB first.
// All outputs are registered from next-state values, so tx never glitches between bits.
module uart_fifo_tx #(
    parameter int CLK_FREQ     = 50000000,
    parameter int BAUD         = 115200,
    parameter int CLKS_PER_BIT = CLK_FREQ / BAUD
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic [7:0]  fifo_q,
    input  logic        fifo_empty,
    output logic        fifo_rdreq,
    output logic        tx,
    output logic        busy,
    output logic        byte_sent,
    output logic [15:0] sent_count
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        LATCH = 3'd2,
        START = 3'd3,
        DATA  = 3'd4,
        STOP  = 3'd5
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] baud_cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [2:0]       bit_idx;
    logic [2:0]       idx_next;
    logic [7:0]       shift;
    logic [7:0]       shift_next;
    logic             tx_next;
    logic             bit_end;
    logic             frame_done;

    assign bit_end    = (baud_cnt == CNT_LAST);
    assign frame_done = (state == STOP) && bit_end;

    always_comb begin
        state_next = state;
        cnt_next   = baud_cnt;
        idx_next   = bit_idx;
        shift_next = shift;
        tx_next    = 1'b1;

        case (state)
            IDLE: begin
                if (enable && !fifo_empty) begin
                    state_next = READ;
                end
            end
            READ: begin
                state_next = LATCH;
            end
            LATCH: begin
                // fifo_q is valid now, one cycle after the read request
                shift_next = fifo_q;
                cnt_next   = '0;
                idx_next   = '0;
                state_next = START;
            end
            START: begin
                if (bit_end) begin
                    cnt_next   = '0;
                    state_next = DATA;
                end else begin
                    cnt_next = baud_cnt + CNT_W'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    cnt_next   = '0;
                    shift_next = {1'b0, shift[7:1]};
                    if (bit_idx == 3'd7) begin
                        state_next = STOP;
                    end else begin
                        idx_next = bit_idx + 3'd1;
                    end
                end else begin
                    cnt_next = baud_cnt + CNT_W'(1);
                end
            end
            STOP: begin
                if (bit_end) begin
                    cnt_next   = '0;
                    state_next = (enable && !fifo_empty) ? READ : IDLE;
                end else begin
                    cnt_next = baud_cnt + CNT_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (state_next == START) begin
            tx_next = 1'b0;
        end else if (state_next == DATA) begin
            tx_next = shift_next[0];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            baud_cnt   <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            tx         <= 1'b1;
            fifo_rdreq <= 1'b0;
            busy       <= 1'b0;
            byte_sent  <= 1'b0;
            sent_count <= '0;
        end else begin
            state      <= state_next;
            baud_cnt   <= cnt_next;
            bit_idx    <= idx_next;
            shift      <= shift_next;
            tx         <= tx_next;
            fifo_rdreq <= (state_next == READ);
            busy       <= (state_next != IDLE);
            byte_sent  <= (state_next == STOP) && (cnt_next == CNT_LAST);
            if (frame_done) begin
                sent_count <= sent_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_uart_fifo_tx.sv
// Bench for uart_fifo_tx at 10 clocks/bit: table of single-byte frames plus
// hand-written sequences for back-to-back, enable gating, mid-frame reset and count wrap.
module tb_uart_fifo_tx;

    logic        clock;
    logic        reset;
    logic        enable;
    logic [7:0]  fifo_q;
    logic        fifo_empty;
    logic        fifo_rdreq;
    logic        tx;
    logic        busy;
    logic        byte_sent;
    logic [15:0] sent_count;

    uart_fifo_tx #(.CLK_FREQ(1000), .BAUD(100)) dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .fifo_q     (fifo_q),
        .fifo_empty (fifo_empty),
        .fifo_rdreq (fifo_rdreq),
        .tx         (tx),
        .busy       (busy),
        .byte_sent  (byte_sent),
        .sent_count (sent_count)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int checks = 0;
    int errors = 0;

    // FIFO model: the main process only appends at wr_ptr, this block only reads.
    logic [7:0] stream [64];
    logic [5:0] wr_ptr = '0;
    logic [5:0] rd_ptr = '0;
    logic       rand_mode = 1'b1;
    logic       prev_empty = 1'b1;
    int         mon_bad = 0;

    initial begin
        fifo_q     = 8'h00;
        fifo_empty = 1'b1;
    end

    always @(negedge clock) begin
        if (fifo_rdreq && prev_empty) mon_bad++;
        if (fifo_rdreq && byte_sent) mon_bad++;
        if (rand_mode) begin
            fifo_empty = 1'($urandom);
            fifo_q     = 8'($urandom);
        end else begin
            if (fifo_rdreq && (rd_ptr != wr_ptr)) begin
                fifo_q = stream[rd_ptr];
                rd_ptr = rd_ptr + 6'd1;
            end
            fifo_empty = (rd_ptr == wr_ptr);
        end
        prev_empty = fifo_empty;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_bytes(input logic [31:0] w, input int n);
        @(posedge clock);
        #2;
        for (int i = 0; i < n; i++) begin
            stream[wr_ptr] = w[31-8*i -: 8];
            wr_ptr = wr_ptr + 6'd1;
        end
    endtask

    // Waits for the read pulse, then follows one whole frame cycle by cycle.
    // Returns at the negedge of the last stop-bit cycle.
    task automatic rx_frame(input logic [9:0] exp_line, input logic [15:0] cnt_before,
                            input int exp_wait, input string name);
        int         w;
        int         lat;
        logic [9:0] got;
        bit         line_ok;
        bit         bs_ok;
        bit         busy_ok;
        w = 0;
        do begin
            @(negedge clock);
            w++;
        end while (!fifo_rdreq && w < 300);
        if (!fifo_rdreq) begin
            chk({name, " rdreq timeout"}, 32'd0, 32'd1);
            return;
        end
        chk({name, " read wait"}, 32'(w), 32'(exp_wait));
        chk({name, " count before"}, 32'(sent_count), 32'(cnt_before));
        lat = 0;
        busy_ok = 1'b1;
        do begin
            @(negedge clock);
            lat++;
            if (busy !== 1'b1 || fifo_rdreq !== 1'b0) busy_ok = 1'b0;
        end while (tx && lat < 20);
        chk({name, " start latency"}, 32'(lat), 32'd2);
        if (tx) return;
        got = '0;
        line_ok = 1'b1;
        bs_ok = 1'b1;
        for (int k = 0; k < 100; k++) begin
            if (k > 0) @(negedge clock);
            if (k % 10 == 5) got[k/10] = tx;
            if (tx !== exp_line[k/10]) line_ok = 1'b0;
            if (byte_sent !== (k == 99)) bs_ok = 1'b0;
            if (busy !== 1'b1 || fifo_rdreq !== 1'b0) busy_ok = 1'b0;
        end
        chk({name, " line bits"}, 32'(got), 32'(exp_line));
        chk({name, " bit hold"}, 32'(line_ok), 32'd1);
        chk({name, " byte_sent pulse"}, 32'(bs_ok), 32'd1);
        chk({name, " busy/rdreq in frame"}, 32'(busy_ok), 32'd1);
    endtask

    typedef struct {
        logic [7:0] data;
        logic [9:0] line;   // bit i is the i-th line level: start, d0..d7, stop
    } vec_t;

    vec_t       vecs [5];
    logic [15:0] exp_cnt;
    int          bad;
    int          w;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{8'h1E, 10'h23C};
        vecs[1] = '{8'hA5, 10'h34A};
        vecs[2] = '{8'h00, 10'h200};
        vecs[3] = '{8'hFF, 10'h3FE};
        vecs[4] = '{8'h34, 10'h268};

        reset  = 1'b0;
        enable = 1'b0;
        exp_cnt = 16'd0;

        // Reset held with random inputs
        for (int i = 0; i < 8; i++) begin
            @(posedge clock);
            #2 enable = 1'($urandom);
            @(negedge clock);
            #1 chk("reset hold", 32'({tx, fifo_rdreq, busy, byte_sent, sent_count}), 32'h80000);
        end
        @(posedge clock);
        #2 rand_mode = 1'b0;
        enable = 1'b1;
        @(posedge clock);
        @(posedge clock);
        #2 reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            chk("idle after reset", 32'({tx, fifo_rdreq, busy, byte_sent, sent_count}), 32'h80000);
        end

        // Table: single frames from IDLE
        foreach (vecs[i]) begin
            push_bytes({vecs[i].data, 24'h0}, 1);
            rx_frame(vecs[i].line, exp_cnt, 2, $sformatf("vec%0d", i));
            exp_cnt = exp_cnt + 16'd1;
            @(negedge clock);
            chk($sformatf("vec%0d count after", i), 32'(sent_count), 32'(exp_cnt));
            chk($sformatf("vec%0d idle after", i), 32'({tx, busy}), 32'h2);
        end

        // Full word, back-to-back with 2-cycle gaps
        push_bytes(32'h1E3470FB, 4);
        rx_frame(10'h23C, exp_cnt, 2, "word b0");
        rx_frame(10'h268, exp_cnt + 16'd1, 1, "word b1");
        rx_frame(10'h2E0, exp_cnt + 16'd2, 1, "word b2");
        rx_frame(10'h3F6, exp_cnt + 16'd3, 1, "word b3");
        exp_cnt = exp_cnt + 16'd4;
        @(negedge clock);
        chk("word count", 32'(sent_count), 32'(exp_cnt));
        chk("word busy falls", 32'(busy), 32'd0);

        // Enable dropped mid-frame
        push_bytes(32'h11223300, 3);
        fork
            rx_frame(10'h222, exp_cnt, 2, "gate b1");
            begin
                repeat (30) @(posedge clock);
                #2 enable = 1'b0;
            end
        join
        exp_cnt = exp_cnt + 16'd1;
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clock);
            if (fifo_rdreq !== 1'b0 || tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        chk("gate held idle", 32'(bad), 32'd0);
        chk("gate count", 32'(sent_count), 32'(exp_cnt));
        @(posedge clock);
        #2 enable = 1'b1;
        rx_frame(10'h244, exp_cnt, 2, "gate b2");
        rx_frame(10'h266, exp_cnt + 16'd1, 1, "gate b3");
        exp_cnt = exp_cnt + 16'd2;
        @(negedge clock);
        chk("gate final count", 32'(sent_count), 32'(exp_cnt));

        // Reset during data bit 4 of 0xA5
        push_bytes(32'hA53C0000, 2);
        w = 0;
        do begin
            @(negedge clock);
            w++;
        end while (!fifo_rdreq && w < 50);
        chk("rst rdreq seen", 32'(fifo_rdreq), 32'd1);
        repeat (2) @(negedge clock);
        chk("rst start bit", 32'(tx), 32'd0);
        repeat (53) @(negedge clock);
        chk("rst bit4 level", 32'(tx), 32'd0);
        #1 reset = 1'b0;
        #1 chk("rst async", 32'({tx, fifo_rdreq, busy, byte_sent, sent_count}), 32'h80000);
        exp_cnt = 16'd0;
        repeat (3) @(posedge clock);
        #2 reset = 1'b1;
        rx_frame(10'h278, exp_cnt, 2, "post-reset 3C");
        exp_cnt = exp_cnt + 16'd1;
        @(negedge clock);
        chk("post-reset count", 32'(sent_count), 32'(exp_cnt));

        // Count wrap
        @(negedge clock);
        force dut.sent_count = 16'hFFFF;
        @(negedge clock);
        release dut.sent_count;
        @(negedge clock);
        chk("wrap preload", 32'(sent_count), 32'h0000FFFF);
        push_bytes(32'h00000000, 1);
        rx_frame(10'h200, 16'hFFFF, 2, "wrap frame");
        @(negedge clock);
        chk("wrap to zero", 32'(sent_count), 32'd0);

        chk("monitor rdreq rules", 32'(mon_bad), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_fifo_tx.md
# uart_fifo_tx

Downstream drain stage of the RSA/RFID output path: reads ciphertext bytes from the 8-bit FIFO that `send_data` fills, and transmits each byte on a UART TX line as 8N1 frames, LSB first. It runs continuously and sends bytes back-to-back while the FIFO is non-empty. It flags per-byte completion and a running byte count for the host/debug logic.

## Interface
- `CLK_FREQ`, 50000000: clock frequency in Hz.
- `BAUD`, 115200: line rate in bit/s.
- `CLKS_PER_BIT`, CLK_FREQ/BAUD (integer division, truncated): clock cycles per UART bit; must be ≥ 2.

- `clock`  in  1  system clock; all logic is on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `enable`  in  1  when 1, new frames may start; when 0, the current frame finishes and no new read is issued.
- `fifo_q`  in  8  FIFO read data, valid the cycle after `fifo_rdreq` (normal-mode FIFO, not show-ahead).
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_rdreq`  out  1  FIFO read request; one-cycle pulse per byte.
- `tx`  out  1  UART serial output; idle level is 1.
- `busy`  out  1  1 from the read pulse through the end of the stop bit.
- `byte_sent`  out  1  one-cycle pulse in the last cycle of each stop bit.
- `sent_count`  out  16  number of completed frames since reset; wraps from 0xFFFF to 0x0000.

## Operation
- FSM states: IDLE, READ, LATCH, START, DATA, STOP.
- IDLE: `tx`=1, `busy`=0. If `enable`=1 and `fifo_empty`=0, go to READ.
- READ (1 cycle): assert `fifo_rdreq`=1 and `busy`=1, then go to LATCH.
- LATCH (1 cycle): capture `fifo_q` into the shift register, clear the baud counter and bit index, then go to START.
- START: `tx`=0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA: `tx`=shift[0] for CLKS_PER_BIT cycles per bit, shifting right after each bit, for 8 bits (index 0..7), then go to STOP.
- STOP: `tx`=1 for CLKS_PER_BIT cycles.
  - In the last cycle of STOP, pulse `byte_sent` and increment `sent_count`.
  - Then go to READ if `enable`=1 and `fifo_empty`=0; otherwise go to IDLE.
- Baud counter counts 0..CLKS_PER_BIT-1 and is reset at every bit boundary. Its width is the minimum that holds CLKS_PER_BIT-1.
- `fifo_rdreq` is never asserted while `fifo_empty`=1. The empty sample that decides the transition is the one in the cycle before READ.
- `enable` is sampled only at frame-start decision points. Deasserting it never truncates a frame.
- Byte order on the line is FIFO order. `send_data` writes the 32-bit word MSB byte first, so 0x1E3470FB goes out as 1E, 34, 70, FB.

## Timing
- Reset values: `tx`=1, `fifo_rdreq`=0, `busy`=0, `byte_sent`=0, `sent_count`=0, state=IDLE.
- Reset asserted mid-frame forces all of the above asynchronously. `tx` returns high immediately, and the partial frame is abandoned without being counted.
- Latency from IDLE with data available:
  - cycle 0: decision in IDLE.
  - cycle 1: READ, `fifo_rdreq`=1.
  - cycle 2: LATCH.
  - cycle 3: first start-bit cycle.
- Frame length: 10×CLKS_PER_BIT cycles, from the first start cycle to the last stop cycle.
- Back-to-back frames: exactly 2 cycles of `tx`=1 (READ and LATCH) between the end of one stop bit and the next start bit. `busy` stays 1 across the gap.
- Simultaneous events:
  - A FIFO write that arrives in the same cycle as the STOP-end decision, while `fifo_empty`=1, is picked up on the next IDLE cycle.
  - `byte_sent` and `fifo_rdreq` are never high in the same cycle.

## Test plan
- Reset: hold `reset`=0 with random inputs → `tx`=1, `fifo_rdreq`=0, `busy`=0, `sent_count`=0. Release with `fifo_empty`=1 → outputs stay idle and `fifo_rdreq` is never asserted.
- Single byte, CLK_FREQ=1000, BAUD=100 (10 clocks/bit): FIFO holds 0x1E → one `fifo_rdreq` pulse, start bit 3 cycles later. Line sequence is 0 | 0,1,1,1,1,0,0,0 | 1, each level held 10 cycles. `byte_sent` pulses once and `sent_count`=1.
- Full word: `send_data` loaded with 0x1E3470FB → bytes decoded from `tx` are 1E, 34, 70, FB in order, with a 2-cycle high gap between frames. `sent_count`=4 and `busy` falls only after the 4th stop bit.
- Enable gating: deassert `enable` during the DATA bits of byte 1 with 3 bytes queued → byte 1 completes, no further `fifo_rdreq`. Reassert `enable` → bytes 2 and 3 follow.
- Reset mid-frame: assert `reset` during bit 4 of 0xA5 → `tx` is 1 in the same cycle and `sent_count` stays 0. After release, the next queued byte transmits cleanly.
- Counter wrap: preload via 65536 frames (or force `sent_count` to 0xFFFF) → the next `byte_sent` takes it to 0x0000.
